// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared types and coin values for the vending controller.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // Controller states; IDLE means zero credit, ACCUM means partial credit
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_t;

    localparam int COIN1  = 1;
    localparam int COIN5  = 5;
    localparam int COIN10 = 10;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/coin_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : coin_edge_detect
// Purpose  : Turns the three coin levels into one-cycle insertion events.
// Revision : 1.0 - initial release
// ============================================================================
module coin_edge_detect (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] coin_lvl,
    output logic [2:0] coin_evt
);

    logic [2:0] r_prev;

    // Remember last cycle's levels; cleared on reset so a coin held across
    // reset release is seen as a fresh insertion exactly once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 3'b000;
        end else begin
            r_prev <= coin_lvl;
        end
    end

    assign coin_evt = coin_lvl & ~r_prev;

endmodule : coin_edge_detect
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl
// Purpose  : Coin-accumulating vending controller with dispense and change
//            handshakes, cancel/refund and overflow rejection.
// Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int W          = 5,
    parameter int PRICE      = 10,
    parameter int MAX_CREDIT = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rmb1,
    input  logic         rmb5,
    input  logic         rmb10,
    input  logic         cancel,
    input  logic         dispense_ack,
    input  logic         change_ack,
    output logic [W-1:0] credit,
    output logic         dispense,
    output logic [W-1:0] change,
    output logic         change_valid,
    output logic         coin_reject
);

    // Sums are kept one bit wider than credit so overflow is visible
    localparam logic [W:0]   C_MAX_X   = (W+1)'(MAX_CREDIT);
    localparam logic [W:0]   C_PRICE_X = (W+1)'(PRICE);
    localparam logic [W-1:0] C_PRICE   = W'(PRICE);

    vend_state_t  r_state;
    vend_state_t  w_state_nxt;
    logic [W-1:0] r_credit;
    logic [W-1:0] w_credit_nxt;
    logic         r_reject;
    logic         w_reject_nxt;

    logic [2:0]   w_evt;
    logic         w_any_evt;
    logic [W:0]   w_value;
    logic [W:0]   w_sum;
    logic [W-1:0] w_remain;

    coin_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .coin_lvl ({rmb10, rmb5, rmb1}),
        .coin_evt (w_evt)
    );

    assign w_any_evt = |w_evt;
    assign w_value   = (w_evt[0] ? (W+1)'(COIN1)  : '0)
                     + (w_evt[1] ? (W+1)'(COIN5)  : '0)
                     + (w_evt[2] ? (W+1)'(COIN10) : '0);
    assign w_sum     = {1'b0, r_credit} + w_value;
    // Never negative: VEND is only entered with credit >= PRICE
    assign w_remain  = r_credit - C_PRICE;

    // State, credit and registered reject pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_reject <= w_reject_nxt;
        end
    end

    // Next state / next credit; coins win over cancel in the same cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_reject_nxt = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_any_evt) begin
                    if (w_sum > C_MAX_X) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_credit_nxt = w_sum[W-1:0];
                        w_state_nxt  = (w_sum >= C_PRICE_X) ? VEND : ACCUM;
                    end
                end else if (cancel && (r_state == ACCUM)) begin
                    w_state_nxt = CHANGE;
                end
            end
            VEND: begin
                w_reject_nxt = w_any_evt;
                if (dispense_ack) begin
                    w_credit_nxt = w_remain;
                    w_state_nxt  = (w_remain != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                w_reject_nxt = w_any_evt;
                if (change_ack) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    // Moore output decode from registered state and credit
    always_comb begin
        dispense     = 1'b0;
        change_valid = 1'b0;
        change       = '0;
        if (r_state == VEND) begin
            dispense = 1'b1;
        end
        if (r_state == CHANGE) begin
            change_valid = 1'b1;
            change       = r_credit;
        end
    end

    assign credit      = r_credit;
    assign coin_reject = r_reject;

endmodule : vend_ctrl
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_ctrl
// Purpose  : Directed self-checking bench for vend_ctrl (default build and a
//            PRICE=25 build for the overflow case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl;

    logic clk = 1'b0;
    logic reset;

    // Default build (W=5, PRICE=10, MAX_CREDIT=31)
    logic       a_rmb1, a_rmb5, a_rmb10, a_cancel, a_dack, a_cack;
    logic [4:0] a_credit, a_change;
    logic       a_disp, a_cv, a_rej;

    // PRICE=25 build
    logic       b_rmb1, b_rmb5, b_rmb10, b_cancel, b_dack, b_cack;
    logic [4:0] b_credit, b_change;
    logic       b_disp, b_cv, b_rej;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        bit         sel_b;
        logic [4:0] credit;
        logic       disp;
        logic       cv;
        logic [4:0] change;
        logic       rej;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    vend_ctrl dut_a (
        .clk(clk), .reset(reset),
        .rmb1(a_rmb1), .rmb5(a_rmb5), .rmb10(a_rmb10),
        .cancel(a_cancel), .dispense_ack(a_dack), .change_ack(a_cack),
        .credit(a_credit), .dispense(a_disp), .change(a_change),
        .change_valid(a_cv), .coin_reject(a_rej)
    );

    vend_ctrl #(.W(5), .PRICE(25), .MAX_CREDIT(31)) dut_b (
        .clk(clk), .reset(reset),
        .rmb1(b_rmb1), .rmb5(b_rmb5), .rmb10(b_rmb10),
        .cancel(b_cancel), .dispense_ack(b_dack), .change_ack(b_cack),
        .credit(b_credit), .dispense(b_disp), .change(b_change),
        .change_valid(b_cv), .coin_reject(b_rej)
    );

    task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs for the next check point
    task automatic push(input string tag, input bit sel_b, input int cr,
                        input bit disp, input bit cv, input int chg, input bit rej);
        exp_t e;
        e.tag    = tag;
        e.sel_b  = sel_b;
        e.credit = 5'(cr);
        e.disp   = disp;
        e.cv     = cv;
        e.change = 5'(chg);
        e.rej    = rej;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        if (!e.sel_b) begin
            cmp({e.tag, ".credit"}, a_credit, e.credit);
            cmp({e.tag, ".dispense"}, {4'd0, a_disp}, {4'd0, e.disp});
            cmp({e.tag, ".change_valid"}, {4'd0, a_cv}, {4'd0, e.cv});
            cmp({e.tag, ".change"}, a_change, e.change);
            cmp({e.tag, ".coin_reject"}, {4'd0, a_rej}, {4'd0, e.rej});
        end else begin
            cmp({e.tag, ".credit"}, b_credit, e.credit);
            cmp({e.tag, ".dispense"}, {4'd0, b_disp}, {4'd0, e.disp});
            cmp({e.tag, ".change_valid"}, {4'd0, b_cv}, {4'd0, e.cv});
            cmp({e.tag, ".change"}, b_change, e.change);
            cmp({e.tag, ".coin_reject"}, {4'd0, b_rej}, {4'd0, e.rej});
        end
    endtask

    // One clock edge, then check just after it
    task automatic tick();
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        reset    = 1'b1;
        a_rmb1   = 0; a_rmb5 = 0; a_rmb10 = 0; a_cancel = 0; a_dack = 0; a_cack = 0;
        b_rmb1   = 0; b_rmb5 = 0; b_rmb10 = 0; b_cancel = 0; b_dack = 0; b_cack = 0;
        #12;
        push("reset_a", 0, 0, 0, 0, 0, 0); check_front();
        push("reset_b", 1, 0, 0, 0, 0, 0); check_front();
        @(negedge clk);
        reset = 1'b0;
        push("idle", 0, 0, 0, 0, 0, 0); tick();

        // Exact price: held rmb5 counts once, second insertion reaches price
        a_rmb5 = 1; push("ex_c1", 0, 5, 0, 0, 0, 0); tick();
        push("ex_hold1", 0, 5, 0, 0, 0, 0); tick();
        push("ex_hold2", 0, 5, 0, 0, 0, 0); tick();
        a_rmb5 = 0; push("ex_low", 0, 5, 0, 0, 0, 0); tick();
        a_rmb5 = 1; push("ex_c2", 0, 10, 1, 0, 0, 0); tick();
        a_rmb5 = 0; push("ex_wait", 0, 10, 1, 0, 0, 0); tick();
        a_dack = 1; push("ex_ack", 0, 0, 0, 0, 0, 0); tick();
        a_dack = 0; push("ex_idle", 0, 0, 0, 0, 0, 0); tick();

        // Vend with change
        a_rmb5 = 1; push("vc_5", 0, 5, 0, 0, 0, 0); tick();
        a_rmb5 = 0; a_rmb1 = 1; push("vc_1", 0, 6, 0, 0, 0, 0); tick();
        a_rmb1 = 0; a_rmb10 = 1; push("vc_10", 0, 16, 1, 0, 0, 0); tick();
        a_rmb10 = 0; a_cack = 1; push("vc_cack_ign", 0, 16, 1, 0, 0, 0); tick();
        a_cack = 0; a_dack = 1; push("vc_dack", 0, 6, 0, 1, 6, 0); tick();
        a_dack = 0; push("vc_hold", 0, 6, 0, 1, 6, 0); tick();
        a_cack = 1; push("vc_cack", 0, 0, 0, 0, 0, 0); tick();
        a_cack = 0; push("vc_idle", 0, 0, 0, 0, 0, 0); tick();

        // Cancel in IDLE is ignored; cancel in ACCUM refunds
        a_cancel = 1; push("cn_idle", 0, 0, 0, 0, 0, 0); tick();
        a_cancel = 0;
        for (int i = 1; i <= 3; i++) begin
            a_rmb1 = 1; push("cn_coin", 0, i, 0, 0, 0, 0); tick();
            a_rmb1 = 0; push("cn_gap", 0, i, 0, 0, 0, 0); tick();
        end
        a_cancel = 1; push("cn_refund", 0, 3, 0, 1, 3, 0); tick();
        a_cancel = 0; push("cn_hold", 0, 3, 0, 1, 3, 0); tick();
        a_cack = 1; push("cn_cack", 0, 0, 0, 0, 0, 0); tick();
        a_cack = 0;

        // Coin and cancel together: coin wins
        a_rmb1 = 1; push("cc_1", 0, 1, 0, 0, 0, 0); tick();
        a_rmb1 = 0; a_rmb5 = 1; a_cancel = 1; push("cc_both", 0, 6, 0, 0, 0, 0); tick();
        a_rmb5 = 0; a_cancel = 0; push("cc_after", 0, 6, 0, 0, 0, 0); tick();
        a_cancel = 1; push("cc_refund", 0, 6, 0, 1, 6, 0); tick();
        a_cancel = 0; a_cack = 1; push("cc_cack", 0, 0, 0, 0, 0, 0); tick();
        a_cack = 0;

        // Overflow reject on PRICE=25 build: 10,10,1,1,1,1 -> 24
        b_rmb10 = 1; push("ov_10a", 1, 10, 0, 0, 0, 0); tick();
        b_rmb10 = 0; push("ov_g0", 1, 10, 0, 0, 0, 0); tick();
        b_rmb10 = 1; push("ov_10b", 1, 20, 0, 0, 0, 0); tick();
        b_rmb10 = 0; push("ov_g1", 1, 20, 0, 0, 0, 0); tick();
        for (int i = 1; i <= 4; i++) begin
            b_rmb1 = 1; push("ov_1", 1, 20 + i, 0, 0, 0, 0); tick();
            b_rmb1 = 0; push("ov_g", 1, 20 + i, 0, 0, 0, 0); tick();
        end
        b_rmb10 = 1; push("ov_rej", 1, 24, 0, 0, 0, 1); tick();
        b_rmb10 = 0; push("ov_rej_end", 1, 24, 0, 0, 0, 0); tick();
        b_rmb1 = 1; push("ov_vend", 1, 25, 1, 0, 0, 0); tick();
        b_rmb1 = 0; push("ov_vend_hold", 1, 25, 1, 0, 0, 0); tick();

        // Simultaneous events, reject and cancel ignored in VEND
        a_rmb1 = 1; a_rmb5 = 1; push("si_both", 0, 6, 0, 0, 0, 0); tick();
        a_rmb1 = 0; a_rmb5 = 0; push("si_gap", 0, 6, 0, 0, 0, 0); tick();
        a_rmb10 = 1; push("si_10", 0, 16, 1, 0, 0, 0); tick();
        a_rmb10 = 0; push("si_vend", 0, 16, 1, 0, 0, 0); tick();
        a_rmb1 = 1; push("si_rej", 0, 16, 1, 0, 0, 1); tick();
        a_rmb1 = 0; a_cancel = 1; push("si_cancel_ign", 0, 16, 1, 0, 0, 0); tick();
        a_cancel = 0; a_dack = 1; push("si_dack", 0, 6, 0, 1, 6, 0); tick();
        a_dack = 0; a_rmb5 = 1; push("si_rej_chg", 0, 6, 0, 1, 6, 1); tick();
        push("si_chg_hold", 0, 6, 0, 1, 6, 0); tick();

        // Reset mid-CHANGE with rmb5 held; it counts once after release
        #3;
        reset = 1'b1;
        #1;
        push("rs_async", 0, 0, 0, 0, 0, 0); check_front();
        @(negedge clk);
        reset = 1'b0;
        push("rs_held5", 0, 5, 0, 0, 0, 0); tick();
        push("rs_held5b", 0, 5, 0, 0, 0, 0); tick();
        a_rmb5 = 0; push("rs_low", 0, 5, 0, 0, 0, 0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_vend_ctrl
`default_nettype wire
